muldiv_div_seq: RTL and testbench

// Iterative radix-2 restoring divider that consumes the conditioned operands and AB_status

---
 rtl/muldiv_div_seq_if.sv | 31 +++
 rtl/muldiv_div_seq.sv | 161 ++++++++++++++++
 tb/tb_muldiv_div_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_div_seq_if.sv
// Handshake and operand bundle between the MULDIV operand stage and the divider.
// Master drives operands and control; slave returns busy/done/result.
interface muldiv_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             kill_i;
    logic             op_div0;
    logic             op_rem;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic [WIDTH-1:0] a_raw_i;
    logic             sign_A;
    logic             sign_B;
    logic [5:0]       AB_status;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, kill_i, op_div0, op_rem,
        output in_A, in_B, a_raw_i, sign_A, sign_B, AB_status,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, kill_i, op_div0, op_rem,
        input  in_A, in_B, a_raw_i, sign_A, sign_B, AB_status,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define MULDIV_DIV_FASTPATH_EN for single-cycle results on trivial operands.
module muldiv_div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic             clk_i,
    input logic             reset_i,
    muldiv_div_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             op_div0_q;
    logic             op_rem_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             div0_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] fix_val;
    logic             fast_hit;
    logic [WIDTH-1:0] fast_val;

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        rem_nxt = shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_nxt    = trial[WIDTH-1:0];
            quo_nxt[0] = 1'b1;
        end
    end

    // Final sign fix; a zero divisor keeps the all-ones quotient unsigned.
    always_comb begin
        neg_q   = op_div0_q & (sign_a_q ^ sign_b_q) & ~div0_q;
        neg_r   = op_div0_q & sign_a_q;
        sel     = op_rem_q ? rem : quo;
        fix_val = (op_rem_q ? neg_r : neg_q) ? (~sel + 1'b1) : sel;
    end

`ifdef MULDIV_DIV_FASTPATH_EN
    // Early-out detection on operand-stage flags, highest priority first.
    always_comb begin
        fast_hit = 1'b1;
        fast_val = '0;
        if (bus.AB_status[3]) begin
            fast_val = bus.op_rem ? bus.a_raw_i : '1;
        end else if (bus.AB_status[0]) begin
            fast_val = '0;
        end else if (bus.AB_status[4]) begin
            fast_val = bus.op_rem ? '0 :
                       (bus.op_div0 ? bus.a_raw_i : bus.in_A);
        end else if (bus.AB_status[5]) begin
            fast_val = bus.op_rem ? '0 : (~bus.a_raw_i + 1'b1);
        end else begin
            fast_hit = 1'b0;
        end
    end
`else
    logic unused_status;

    // Every op takes the iterative path; only B0 is consulted.
    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
    end

    assign unused_status = ^{bus.AB_status[5:4], bus.AB_status[2:0],
                             bus.a_raw_i};
`endif

    // Control FSM with registered busy/done/result.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            op_div0_q <= 1'b0;
            op_rem_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else if (bus.kill_i && state != IDLE) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i && !bus.kill_i) begin
                        op_div0_q <= bus.op_div0;
                        op_rem_q  <= bus.op_rem;
                        sign_a_q  <= bus.sign_A;
                        sign_b_q  <= bus.sign_B;
                        div0_q    <= bus.AB_status[3];
                        dvs       <= bus.in_B;
                        rem       <= '0;
                        quo       <= bus.in_A;
                        cnt       <= CNT_W'(WIDTH);
                        if (fast_hit) begin
                            result_q <= fast_val;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            busy_q <= 1'b1;
                            state  <= ITER;
                        end
                    end
                end
                ITER: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_val;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_div_seq.sv
// Self-checking bench for muldiv_div_seq against an arithmetic reference.
// Honours MULDIV_DIV_FASTPATH_EN for expected latency.
module tb_muldiv_div_seq;
    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] prev;

    muldiv_div_seq_if #(.WIDTH(32)) bus();

    muldiv_div_seq #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operand stage model: magnitudes for signed ops plus status flags.
    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic rm);
        bus.op_div0   = sgn;
        bus.op_rem    = rm;
        bus.a_raw_i   = a;
        bus.sign_A    = a[31];
        bus.sign_B    = b[31];
        bus.in_A      = (sgn && a[31]) ? -a : a;
        bus.in_B      = (sgn && b[31]) ? -b : b;
        bus.AB_status = {sgn && b == 32'hFFFF_FFFF, b == 32'd1, b == 32'd0,
                         sgn && a == 32'hFFFF_FFFF, a == 32'd1, a == 32'd0};
    endtask

    function automatic logic [31:0] ref_result(input logic [31:0] a,
                                               input logic [31:0] b,
                                               input logic sgn,
                                               input logic rm);
        int sa;
        int sb;
        if (b == 0) return rm ? a : 32'hFFFF_FFFF;
        if (!sgn) return rm ? a % b : a / b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return rm ? 32'd0 : 32'h8000_0000;
        sa = a;
        sb = b;
        return rm ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic bit is_fast(input logic [31:0] a, input logic [31:0] b,
                                   input logic sgn);
`ifdef MULDIV_DIV_FASTPATH_EN
        return b == 0 || a == 0 || b == 1 || (sgn && b == 32'hFFFF_FFFF);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 50);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic sgn,
                          input logic rm, input bit jitter);
        logic [31:0] exp;
        logic [31:0] got;
        bit          fast;
        int          lat;
        int          done_at;
        int          pulses;
        bit          busy_ok;
        exp     = ref_result(a, b, sgn, rm);
        fast    = is_fast(a, b, sgn);
        lat     = fast ? 1 : 34;
        done_at = -1;
        pulses  = 0;
        busy_ok = 1'b1;
        got     = 'x;
        @(negedge clk);
        drive(a, b, sgn, rm);
        bus.start_i = 1'b1;
        for (int c = 1; c <= lat + 2; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = c;
                    got     = bus.result_o;
                end
            end
            if (bus.busy_o !== (!fast && c <= 33)) busy_ok = 1'b0;
            if (jitter && c < lat) begin
                bus.start_i = 1'($urandom_range(0, 1));
                drive(pick(), pick(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
            end else begin
                bus.start_i = 1'b0;
            end
        end
        check({tag, "_lat"}, 32'(done_at), 32'(lat));
        check({tag, "_res"}, got, exp);
        check({tag, "_pulse"}, 32'(pulses), 32'd1);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_hold"}, bus.result_o, exp);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_res", bus.result_o, 32'd0);
        @(negedge clk);
        reset_i = 1'b1;

        run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        check("divu_100_7_k", bus.result_o, 32'd14);
        run_op("rem_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0);
        check("rem_m7_2_k", bus.result_o, 32'hFFFF_FFFF);
        run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        check("div_m7_2_k", bus.result_o, 32'hFFFF_FFFD);
        run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("div_ovf_k", bus.result_o, 32'h8000_0000);
        run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        check("rem_ovf_k", bus.result_o, 32'd0);
        run_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0, 1'b0);
        check("div_m5_0_k", bus.result_o, 32'hFFFF_FFFF);
        run_op("rem_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b1, 1'b0);
        check("rem_m5_0_k", bus.result_o, 32'hFFFF_FFFB);
        run_op("divu_x_0", 32'h8000_0005, 32'd0, 1'b0, 1'b0, 1'b0);

        prev = bus.result_o;
        @(negedge clk);
        drive(32'd50, 32'd5, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (c == 11) begin
                check("kill_busy", 32'(bus.busy_o), 32'd0);
                check("kill_done", 32'(bus.done_o), 32'd0);
                check("kill_res", bus.result_o, prev);
                bus.kill_i = 1'b0;
            end else if (bus.done_o === 1'b1) begin
                check("kill_early_done", 32'd1, 32'd0);
            end
            if (c == 10) bus.kill_i = 1'b1;
        end
        @(posedge clk);
        run_op("after_kill", 32'd50, 32'd5, 1'b0, 1'b0, 1'b0);

        prev = bus.result_o;
        @(negedge clk);
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        bus.kill_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.kill_i  = 1'b0;
        check("sk_busy", 32'(bus.busy_o), 32'd0);
        check("sk_done", 32'(bus.done_o), 32'd0);
        @(posedge clk);
        #1;
        check("sk_done2", 32'(bus.done_o), 32'd0);
        check("sk_res", bus.result_o, prev);

        @(negedge clk);
        drive(32'd12345, 32'd17, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
        end
        reset_i = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_done", 32'(bus.done_o), 32'd0);
        check("mid_rst_res", bus.result_o, 32'd0);
        @(negedge clk);
        reset_i = 1'b1;
        run_op("post_rst", 32'd12345, 32'd17, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("rnd%0d", i), pick(), pick(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   i[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
